aes_dec_feeder: RTL and testbench

Input-side controller placed directly upstream of the pipelined AES-128 decryption core. It owns the cipher key and sequences the core's round-key expansion. It buffers incoming ciphertext blocks behind a valid/ready handshake and issues them to the core at up to one block per cycle. It also produces a plaintext-valid strobe aligned with the core's output, and drains the pipeline before accepting a key change.

---
 rtl/aes_dec_feeder.sv | 205 ++++++++++++++++++++
 tb/tb_aes_dec_feeder.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/aes_dec_feeder.sv
// aes_dec_feeder
// Input-side controller for a pipelined AES-128 decryption core. It owns the
// cipher key, sequences the core's round-key expansion, buffers ciphertext in
// a small FIFO, issues up to one block per cycle to the core, and raises
// pt_valid when the core's output holds a plaintext. A key change is held
// back until every block queued or in flight under the old key has completed.
//
// Ports:
//   clk, rst     clock (rising edge), asynchronous active-low reset
//   key_in       new cipher key, sampled when key_load=1 in IDLE or RUN
//   key_load     one-cycle request to load key_in
//   key_ready    round keys are valid and blocks may issue
//   ct_in        ciphertext block, with ct_valid/ct_ready handshake
//   dec_in       core IN, driven combinationally from the FIFO head
//   dec_key      core KEY, changes only when a key load begins
//   dec_enable   core enable, one per issued block
//   dec_fsm_en   core key-expansion enable, high for KEY_LOAD_CYCLES cycles
//   pt_valid     core OUT holds a valid plaintext this cycle
//   busy         FIFO non-empty or any block still in the core pipeline
module aes_dec_feeder #(
  parameter int BLOCK_LENGTH    = 128,
  parameter int FIFO_DEPTH      = 4,
  parameter int PIPE_LATENCY    = 11,
  parameter int KEY_LOAD_CYCLES = 12
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [BLOCK_LENGTH-1:0] key_in,
  input  logic                    key_load,
  output logic                    key_ready,
  input  logic [BLOCK_LENGTH-1:0] ct_in,
  input  logic                    ct_valid,
  output logic                    ct_ready,
  output logic [BLOCK_LENGTH-1:0] dec_in,
  output logic [BLOCK_LENGTH-1:0] dec_key,
  output logic                    dec_enable,
  output logic                    dec_fsm_en,
  output logic                    pt_valid,
  output logic                    busy
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = AW + 1;
  localparam int CW = $clog2(KEY_LOAD_CYCLES + 1);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_KEY_LOAD = 2'd1,
    ST_RUN      = 2'd2,
    ST_DRAIN    = 2'd3
  } state_t;

  state_t                  state_r;
  state_t                  state_nxt_s;
  logic [CW-1:0]           cnt_r;
  logic [CW-1:0]           cnt_nxt_s;
  logic [PW-1:0]           wr_ptr_r;
  logic [PW-1:0]           rd_ptr_r;
  logic [BLOCK_LENGTH-1:0] mem_r [FIFO_DEPTH];
  logic [BLOCK_LENGTH-1:0] last_in_r;
  logic [BLOCK_LENGTH-1:0] key_r;
  logic [BLOCK_LENGTH-1:0] pend_key_r;
  logic [PIPE_LATENCY-1:0] pipe_r;

  logic                    empty_s;
  logic                    full_s;
  logic                    push_s;
  logic                    pop_s;
  logic                    load_key_s;
  logic                    latch_pend_s;
  logic                    commit_pend_s;
  logic                    pipe_clear_next_s;
  logic                    key_ready_s;
  logic                    ct_ready_s;
  logic                    fsm_en_s;

  // FIFO status from the extra pointer wrap bit.
  always_comb begin
    empty_s = (wr_ptr_r == rd_ptr_r);
    full_s  = (wr_ptr_r[AW] != rd_ptr_r[AW]) &&
              (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
    // True when nothing older than the output stage is in the pipe, i.e. after
    // this edge the pipeline is empty provided no new block issues now.
    pipe_clear_next_s = (pipe_r[PIPE_LATENCY-2:0] == {(PIPE_LATENCY-1){1'b0}});
  end

  // Next-state, handshake and core control decode.
  always_comb begin
    state_nxt_s   = state_r;
    cnt_nxt_s     = cnt_r;
    load_key_s    = 1'b0;
    latch_pend_s  = 1'b0;
    commit_pend_s = 1'b0;
    key_ready_s   = 1'b0;
    ct_ready_s    = 1'b0;
    fsm_en_s      = 1'b0;
    pop_s         = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (key_load) begin
          state_nxt_s = ST_KEY_LOAD;
          cnt_nxt_s   = CW'(KEY_LOAD_CYCLES);
          load_key_s  = 1'b1;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_KEY_LOAD: begin
        fsm_en_s   = 1'b1;
        ct_ready_s = !full_s;
        if (cnt_r == CW'(1)) begin
          state_nxt_s = ST_RUN;
          cnt_nxt_s   = CW'(0);
        end else begin
          cnt_nxt_s   = cnt_r - CW'(1);
        end
      end
      ST_RUN: begin
        key_ready_s = 1'b1;
        ct_ready_s  = !full_s;
        pop_s       = !empty_s;
        if (key_load) begin
          state_nxt_s  = ST_DRAIN;
          latch_pend_s = 1'b1;
        end else begin
          state_nxt_s  = ST_RUN;
        end
      end
      ST_DRAIN: begin
        pop_s = !empty_s;
        // Leave as the last old-key plaintext is being presented.
        if (empty_s && pipe_clear_next_s) begin
          state_nxt_s   = ST_KEY_LOAD;
          cnt_nxt_s     = CW'(KEY_LOAD_CYCLES);
          commit_pend_s = 1'b1;
        end else begin
          state_nxt_s   = ST_DRAIN;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
        cnt_nxt_s   = CW'(0);
      end
    endcase
    push_s = ct_valid && ct_ready_s;
  end

  // Output drive; dec_in is combinational because the core samples IN and
  // enable on the same edge.
  always_comb begin
    key_ready  = key_ready_s;
    ct_ready   = ct_ready_s;
    dec_fsm_en = fsm_en_s;
    dec_enable = pop_s;
    dec_key    = key_r;
    pt_valid   = pipe_r[PIPE_LATENCY-1];
    busy       = !empty_s || (pipe_r != {PIPE_LATENCY{1'b0}});
    if (empty_s) begin
      dec_in = last_in_r;
    end else begin
      dec_in = mem_r[rd_ptr_r[AW-1:0]];
    end
  end

  // Control state, key registers, FIFO pointers and in-flight shift register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r    <= ST_IDLE;
      cnt_r      <= CW'(0);
      wr_ptr_r   <= PW'(0);
      rd_ptr_r   <= PW'(0);
      last_in_r  <= {BLOCK_LENGTH{1'b0}};
      key_r      <= {BLOCK_LENGTH{1'b0}};
      pend_key_r <= {BLOCK_LENGTH{1'b0}};
      pipe_r     <= {PIPE_LATENCY{1'b0}};
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
      pipe_r  <= {pipe_r[PIPE_LATENCY-2:0], pop_s};
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PW'(1);
      end
      if (pop_s) begin
        rd_ptr_r  <= rd_ptr_r + PW'(1);
        last_in_r <= mem_r[rd_ptr_r[AW-1:0]];
      end
      if (load_key_s) begin
        key_r <= key_in;
      end else if (commit_pend_s) begin
        key_r <= pend_key_r;
      end
      if (latch_pend_s) begin
        pend_key_r <= key_in;
      end
    end
  end

  // FIFO storage; contents are only observable while the FIFO is non-empty.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r[AW-1:0]] <= ct_in;
    end
  end

endmodule

// File: tb/tb_aes_dec_feeder.sv
// Self-checking bench for aes_dec_feeder. A transaction-level reference model
// (queue of buffered blocks, list of plaintext due times, key-load countdown)
// predicts every output each cycle from the interface rules.
module tb_aes_dec_feeder;

  localparam int LAT = 11;
  localparam int KLC = 12;
  localparam int DEPTH = 4;
  localparam int M_IDLE = 0;
  localparam int M_KL = 1;
  localparam int M_RUN = 2;
  localparam int M_DRAIN = 3;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [127:0] key_in = 128'd0;
  logic         key_load = 1'b0;
  logic         key_ready;
  logic [127:0] ct_in = 128'd0;
  logic         ct_valid = 1'b0;
  logic         ct_ready;
  logic [127:0] dec_in;
  logic [127:0] dec_key;
  logic         dec_enable;
  logic         dec_fsm_en;
  logic         pt_valid;
  logic         busy;

  aes_dec_feeder dut (
    .clk(clk), .rst(rst), .key_in(key_in), .key_load(key_load),
    .key_ready(key_ready), .ct_in(ct_in), .ct_valid(ct_valid),
    .ct_ready(ct_ready), .dec_in(dec_in), .dec_key(dec_key),
    .dec_enable(dec_enable), .dec_fsm_en(dec_fsm_en),
    .pt_valid(pt_valid), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass = 0;
  int cyc = 0;

  // reference model state
  int           m_mode;
  int           m_kl_left;
  logic [127:0] m_q[$];
  int           m_pt[$];
  logic [127:0] m_key;
  logic [127:0] m_pend;
  logic [127:0] m_last;

  logic         e_ct_ready;
  logic         e_en;
  logic         e_pt;

  task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, obs, exp);
  endtask

  task automatic model_reset();
    m_mode = M_IDLE;
    m_kl_left = 0;
    m_q.delete();
    m_pt.delete();
    m_key = 128'd0;
    m_pend = 128'd0;
    m_last = 128'd0;
  endtask

  task automatic check_outputs();
    e_ct_ready = (m_mode == M_KL || m_mode == M_RUN) && (m_q.size() < DEPTH);
    e_en = (m_mode == M_RUN || m_mode == M_DRAIN) && (m_q.size() > 0);
    e_pt = (m_pt.size() > 0) && (m_pt[0] == cyc);
    check_eq("key_ready", key_ready, m_mode == M_RUN);
    check_eq("dec_fsm_en", dec_fsm_en, m_mode == M_KL);
    check_eq("ct_ready", ct_ready, e_ct_ready);
    check_eq("dec_enable", dec_enable, e_en);
    check_eq("dec_in", dec_in, (m_q.size() > 0) ? m_q[0] : m_last);
    check_eq("dec_key", dec_key, m_key);
    check_eq("pt_valid", pt_valid, e_pt);
    check_eq("busy", busy, (m_q.size() > 0) || (m_pt.size() > 0));
  endtask

  // Applies the current inputs to the model as the coming clock edge will.
  task automatic model_advance();
    bit drained;
    drained = (m_q.size() == 0) && (m_pt.size() == 0 || m_pt[$] <= cyc);
    if (e_pt) void'(m_pt.pop_front());
    if (e_en) begin
      m_last = m_q.pop_front();
      m_pt.push_back(cyc + LAT);
    end
    if (ct_valid && e_ct_ready) m_q.push_back(ct_in);
    case (m_mode)
      M_IDLE: if (key_load) begin m_mode = M_KL; m_kl_left = KLC; m_key = key_in; end
      M_KL: begin
        m_kl_left--;
        if (m_kl_left == 0) m_mode = M_RUN;
      end
      M_RUN: if (key_load) begin m_mode = M_DRAIN; m_pend = key_in; end
      M_DRAIN: if (drained) begin m_mode = M_KL; m_kl_left = KLC; m_key = m_pend; end
      default: m_mode = M_IDLE;
    endcase
    cyc++;
  endtask

  task automatic step(input bit v, input logic [127:0] d, input bit kl, input logic [127:0] k);
    ct_valid = v;
    ct_in = d;
    key_load = kl;
    key_in = k;
    #3;
    check_outputs();
    model_advance();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, rnd128(), 1'b0, rnd128());
  endtask

  initial begin
    logic [127:0] fips_key;
    logic [127:0] fips_ct;
    fips_key = 128'h000102030405060708090a0b0c0d0e0f;
    fips_ct  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    model_reset();
    #2;
    check_outputs();
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;

    // IDLE: offered blocks are refused
    for (int i = 0; i < 3; i++) step(1'b1, rnd128(), 1'b0, 128'd0);
    // key load, with ct_valid held so the FIFO fills and stalls during KEY_LOAD
    step(1'b0, 128'd0, 1'b1, fips_key);
    for (int i = 0; i < 16; i++) step(1'b1, rnd128(), 1'b1, rnd128());
    idle(20);
    // single FIPS-197 block
    step(1'b1, fips_ct, 1'b0, 128'd0);
    idle(15);
    // 20 back-to-back blocks
    for (int i = 0; i < 20; i++) step(1'b1, rnd128(), 1'b0, 128'd0);
    idle(15);
    // key change with blocks in flight
    for (int i = 0; i < 5; i++) step(1'b1, rnd128(), 1'b0, 128'd0);
    step(1'b1, rnd128(), 1'b1, rnd128());
    for (int i = 0; i < 6; i++) step(1'b1, rnd128(), 1'b0, 128'd0);
    idle(30);
    step(1'b1, rnd128(), 1'b0, 128'd0);
    idle(15);
    // randomized traffic with occasional key changes
    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 3) != 0, rnd128(), $urandom_range(0, 39) == 0, rnd128());
    idle(50);
    // mid-stream reset with blocks in flight
    for (int i = 0; i < 6; i++) step(1'b1, rnd128(), 1'b0, 128'd0);
    rst = 1'b0;
    model_reset();
    #1;
    check_outputs();
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;
    for (int i = 0; i < 20; i++) step(1'b1, rnd128(), 1'b0, 128'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
